// File: rtl/share_reporter.sv
// Result-return path: queues winning (time, nonce) shares and streams each one
// as a 10-byte frame (sync, time, nonce, XOR checksum) over a valid/ready byte link.
module share_reporter #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       share_valid,
  input  logic [31:0]                share_time,
  input  logic [31:0]                share_nonce,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [63:0]      share_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  state_t           state_reg;
  state_t           state_next;
  logic [63:0]      frame_reg;
  logic [3:0]       index_reg;
  logic [3:0]       index_next;
  logic [7:0]       csum_reg;
  logic [7:0]       csum_next;
  logic             overflow_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             accept;
  logic [7:0]       payload_bytes [8];
  logic [7:0]       cur_byte;

  assign fifo_full  = (count_reg == CNT_W'(DEPTH));
  assign fifo_empty = (count_reg == '0);

  // A pop in the same cycle frees a slot, so a full FIFO still takes the share.
  assign push   = share_valid && (!fifo_full || pop);
  assign drop   = share_valid && fifo_full && !pop;
  assign accept = (state_reg == SEND) && tx_ready;

  // Payload byte k is frame_reg most-significant first: time[31:24] .. nonce[7:0].
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_payload
      assign payload_bytes[gi] = frame_reg[63-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    cur_byte = 8'h00;
    if (index_reg == 4'd0) begin
      cur_byte = SYNC_BYTE;
    end else if (index_reg <= 4'd8) begin
      cur_byte = payload_bytes[3'(index_reg - 4'd1)];
    end else begin
      cur_byte = csum_reg;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    csum_next  = csum_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SEND;
          index_next = 4'd0;
          csum_next  = 8'h00;
        end
      end
      SEND: begin
        if (accept) begin
          index_next = index_reg + 4'd1;
          if (index_reg >= 4'd1 && index_reg <= 4'd8) begin
            csum_next = csum_reg ^ cur_byte;
          end
          if (index_reg == 4'd9) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage array kept reset-free so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      share_mem[wr_ptr_reg] <= {share_time, share_nonce};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      index_reg    <= 4'd0;
      csum_reg     <= 8'h00;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      frame_reg    <= 64'h0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      csum_reg  <= csum_next;
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        frame_reg  <= share_mem[rd_ptr_reg];
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign tx_valid   = (state_reg == SEND);
  assign tx_data    = tx_valid ? cur_byte : 8'h00;
  assign busy       = tx_valid;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_share_reporter.sv
// Directed bench for share_reporter: frame content, latency, stalls, overflow,
// push/pop collision, mid-frame reset and pointer wrap.
module tb_share_reporter;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        share_valid = 1'b0;
  logic [31:0] share_time = 32'h0;
  logic [31:0] share_nonce = 32'h0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] cap_bytes [10];
  int         cap_n;
  int         cap_gap;
  int         cap_glitch;

  always #5 CLK = ~CLK;

  share_reporter #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK),
    .RST(RST),
    .share_valid(share_valid),
    .share_time(share_time),
    .share_nonce(share_nonce),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .fifo_count(fifo_count),
    .busy(busy),
    .overflow(overflow)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] t, input logic [31:0] n, input int i);
    logic [63:0] p;
    logic [7:0]  c;
    p = {t, n};
    if (i == 0) return 8'hA5;
    if (i <= 8) return p[63-8*(i-1) -: 8];
    c = 8'h00;
    for (int k = 0; k < 8; k++) c = c ^ p[63-8*k -: 8];
    return c;
  endfunction

  // Stimulus only: one strobe, returns at the negedge after the capturing edge.
  task automatic strobe(input logic [31:0] t, input logic [31:0] n);
    share_time  = t;
    share_nonce = n;
    share_valid = 1'b1;
    @(negedge CLK);
    share_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    share_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Records one frame; counts idle cycles before it and tx_data changes during stalls.
  task automatic capture_frame(input bit rnd);
    int         cyc;
    bit         hold;
    logic [7:0] held;
    for (int i = 0; i < 10; i++) cap_bytes[i] = 8'hxx;
    cap_n = 0; cap_gap = 0; cap_glitch = 0; cyc = 0; hold = 1'b0; held = 8'h00;
    while (tx_valid !== 1'b1 && cyc < 50) begin
      @(negedge CLK);
      cap_gap++; cyc++;
    end
    while (cap_n < 10 && cyc < 400 && tx_valid === 1'b1) begin
      if (hold && tx_data !== held) cap_glitch++;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_ready) begin
        cap_bytes[cap_n] = tx_data;
        cap_n++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        held = tx_data;
      end
      @(negedge CLK);
      cyc++;
    end
    tx_ready = 1'b1;
    $display("frame: %0d bytes, gap %0d, stall glitches %0d, bytes %02h %02h %02h %02h %02h %02h %02h %02h %02h %02h",
             cap_n, cap_gap, cap_glitch, cap_bytes[0], cap_bytes[1], cap_bytes[2], cap_bytes[3],
             cap_bytes[4], cap_bytes[5], cap_bytes[6], cap_bytes[7], cap_bytes[8], cap_bytes[9]);
  endtask

  task automatic test_reset();
    RST = 1'b1; share_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    logic [7:0] tab [10];
    tab = '{8'hA5, 8'h13, 8'h0D, 8'hAE, 8'h51, 8'h3A, 8'hEB, 8'h9B, 8'hB8, 8'h13};
    tx_ready = 1'b1;
    strobe(32'h130dae51, 32'h3aeb9bb8);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count_after_strobe: got %0d want 1", fifo_count); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_after_strobe: got %b want 0", tx_valid); end
    capture_frame(1'b0);
    n_cmp++; if (cap_gap !== 1) begin n_bad++; $display("FAIL single_latency_gap: got %0d want 1", cap_gap); end
    n_cmp++; if (cap_n !== 10) begin n_bad++; $display("FAIL single_byte_count: got %0d want 10", cap_n); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (cap_bytes[i] !== tab[i]) begin n_bad++; $display("FAIL single_byte%0d: got %02h want %02h", i, cap_bytes[i], tab[i]); end
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_after: got %b want 0", tx_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_count_after: got %0d want 0", fifo_count); end
  endtask

  task automatic test_random_ready();
    logic [7:0] tab [10];
    tab = '{8'hA5, 8'h13, 8'h0D, 8'hAE, 8'h51, 8'h3A, 8'hEB, 8'h9B, 8'hB8, 8'h13};
    strobe(32'h130dae51, 32'h3aeb9bb8);
    capture_frame(1'b1);
    n_cmp++; if (cap_n !== 10) begin n_bad++; $display("FAIL rand_byte_count: got %0d want 10", cap_n); end
    n_cmp++; if (cap_glitch !== 0) begin n_bad++; $display("FAIL rand_stall_stability: got %0d changes want 0", cap_glitch); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (cap_bytes[i] !== tab[i]) begin n_bad++; $display("FAIL rand_byte%0d: got %02h want %02h", i, cap_bytes[i], tab[i]); end
    end
  endtask

  task automatic test_burst_overflow();
    int seen;
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      share_time  = 32'h0B00_0000 | 32'(i);
      share_nonce = 32'(i);
      share_valid = 1'b1;
      @(negedge CLK);
    end
    share_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL burst_count: got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL burst_overflow: got %b want 1", overflow); end
    n_cmp++; if (tx_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL burst_in_flight: got valid %b busy %b want 1 1", tx_valid, busy); end
    for (int f = 1; f <= 5; f++) begin
      capture_frame(1'b0);
      n_cmp++;
      if (cap_gap !== ((f == 1) ? 0 : 1)) begin n_bad++; $display("FAIL burst_gap_f%0d: got %0d want %0d", f, cap_gap, (f == 1) ? 0 : 1); end
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (cap_bytes[i] !== exp_byte(32'h0B00_0000 | 32'(f), 32'(f), i)) begin
          n_bad++;
          $display("FAIL burst_f%0d_byte%0d: got %02h want %02h", f, i, cap_bytes[i], exp_byte(32'h0B00_0000 | 32'(f), 32'(f), i));
        end
      end
    end
    seen = 0;
    repeat (5) begin
      if (tx_valid === 1'b1) seen++;
      @(negedge CLK);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL burst_dropped_share_sent: got %0d valid cycles want 0", seen); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL burst_overflow_sticky: got %b want 1", overflow); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL burst_count_end: got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_midframe();
    int seen;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      share_time  = 32'h2100_0000 + 32'(i);
      share_nonce = 32'h21 + 32'(i);
      share_valid = 1'b1;
      @(negedge CLK);
    end
    share_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL rstmid_queued: got %0d want 2", fifo_count); end
    tx_ready = 1'b1;
    repeat (5) @(negedge CLK);
    n_cmp++;
    if (tx_data !== exp_byte(32'h2100_0000, 32'h21, 5)) begin
      n_bad++; $display("FAIL rstmid_byte5: got %02h want %02h", tx_data, exp_byte(32'h2100_0000, 32'h21, 5));
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_fifo_count: got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_tx_data: got %02h want 00", tx_data); end
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      if (tx_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_discard: got %0d valid cycles want 0", seen); end
    strobe(32'hdeadbeef, 32'h01234567);
    capture_frame(1'b0);
    n_cmp++; if (cap_gap !== 1) begin n_bad++; $display("FAIL rstmid_new_gap: got %0d want 1", cap_gap); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (cap_bytes[i] !== exp_byte(32'hdeadbeef, 32'h01234567, i)) begin
        n_bad++; $display("FAIL rstmid_new_byte%0d: got %02h want %02h", i, cap_bytes[i], exp_byte(32'hdeadbeef, 32'h01234567, i));
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      share_time  = 32'h3100_0000 + 32'(i);
      share_nonce = 32'h31 + 32'(i);
      share_valid = 1'b1;
      @(negedge CLK);
    end
    share_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL coll_full: got %0d want 4", fifo_count); end
    tx_ready = 1'b1;
    repeat (10) @(negedge CLK);
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL coll_idle_cycle: got %b want 0", tx_valid); end
    strobe(32'h3100_0005, 32'h36);
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL coll_count: got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL coll_overflow: got %b want 0", overflow); end
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin n_bad++; $display("FAIL coll_next_sync: got valid %b data %02h want 1 a5", tx_valid, tx_data); end
    for (int f = 1; f <= 5; f++) begin
      capture_frame(1'b0);
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (cap_bytes[i] !== exp_byte(32'h3100_0000 + 32'(f), 32'h31 + 32'(f), i)) begin
          n_bad++;
          $display("FAIL coll_f%0d_byte%0d: got %02h want %02h", f, i, cap_bytes[i], exp_byte(32'h3100_0000 + 32'(f), 32'h31 + 32'(f), i));
        end
      end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL coll_overflow_end: got %b want 0", overflow); end
  endtask

  task automatic test_wrap();
    logic [31:0] t;
    logic [31:0] n;
    for (int k = 0; k < 3*DEPTH; k++) begin
      t = 32'h5000_0000 + 32'(k) * 32'h0101_0101;
      n = 32'(k + 1) * 32'h9e37_79b9;
      strobe(t, n);
      capture_frame(1'b0);
      n_cmp++; if (cap_n !== 10) begin n_bad++; $display("FAIL wrap_k%0d_count: got %0d want 10", k, cap_n); end
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (cap_bytes[i] !== exp_byte(t, n, i)) begin
          n_bad++; $display("FAIL wrap_k%0d_byte%0d: got %02h want %02h", k, i, cap_bytes[i], exp_byte(t, n, i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_ready();
    test_burst_overflow();
    test_reset_midframe();
    test_collision();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/share_reporter.md
# share_reporter

Result-return path of the miner: captures winning (time, nonce) pairs from `sha_hasher`'s `valid_out`/`time_out`/`nonce_out` and streams each one to the host-link transmitter as a framed byte packet over a valid/ready handshake. It sits between the hasher output and the UART/host byte interface, the opposite end of the work-load path that feeds the hasher. A small FIFO absorbs bursts of shares. Loss is flagged, never silent.

## Interface
- `DEPTH`, 4: share FIFO entries (power of two, ≥2)
- `SYNC_BYTE`, 8'hA5: first byte of every frame

- `CLK`  in  1  clock, all logic on rising edge
- `RST`  in  1  synchronous, active-high reset
- `share_valid`  in  1  one-cycle strobe: `share_time`/`share_nonce` hold a valid share
- `share_time`  in  32  time word of share
- `share_nonce`  in  32  nonce word of share
- `tx_data`  out  8  frame byte
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  downstream accepts byte
- `fifo_count`  out  $clog2(DEPTH+1)  entries stored, excluding the frame in flight
- `busy`  out  1  frame in flight (state SEND)
- `overflow`  out  1  sticky: a share was dropped

## Operation
- Frame, 10 bytes, fixed order:
  - `SYNC_BYTE`
  - time[31:24], [23:16], [15:8], [7:0]
  - nonce[31:24] … nonce[7:0]
  - checksum: XOR of the 8 payload bytes; sync byte excluded
- FIFO push: `share_valid`=1 and FIFO not full → entry written.
- FIFO full, `share_valid`=1, no pop that cycle → share dropped, `overflow`←1.
- FIFO full, `share_valid`=1 and pop in the same cycle → push accepted, no drop.
- `overflow` clears only on `RST`.
- FSM:
  - IDLE: if `fifo_count`≠0, pop head into 64-bit frame register, clear byte index and checksum, go to SEND.
  - SEND: drive byte[index]. On `tx_valid && tx_ready`, index+1 and fold payload bytes into the running checksum. On acceptance of byte 9, go to IDLE.
- `tx_data` is a mux of frame register/index/checksum. It stays stable while `tx_valid`=1 and `tx_ready`=0.
- `tx_valid` = (state==SEND). It never drops mid-frame except on `RST`.
- Ordering is strict FIFO.
- FIFO pointers are $clog2(DEPTH) bits with natural wrap. A separate count register tracks full/empty.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `busy`=0, `fifo_count`=0, `overflow`=0, FSM=IDLE, pointers 0.
- `RST` asserted mid-frame: the next cycle shows reset values. The in-flight frame and all FIFO contents are discarded.
- Latency, share to first byte:
  - `share_valid` at edge N → `fifo_count`=1 after N.
  - Pop at edge N+1 → `tx_valid`=1 with `SYNC_BYTE` after N+1.
  - The pop decrements `fifo_count` at that same edge.
- Throughput: one byte per cycle with `tx_ready` held high, so a frame takes 10 cycles. Back-to-back frames have exactly one idle cycle (`tx_valid`=0) between the last byte and the next `SYNC_BYTE`.
- `busy` equals `tx_valid`.

## Test plan
- Single share time=32'h130dae51, nonce=32'h3aeb9bb8, `tx_ready`=1 →
  - bytes A5 13 0D AE 51 3A EB 9B B8 13 on 10 consecutive cycles, first one 2 edges after the strobe;
  - then `tx_valid`=0, `fifo_count`=0.
- Same share with `tx_ready` toggled pseudo-randomly →
  - identical byte sequence;
  - `tx_data` never changes while `tx_valid`=1 and `tx_ready`=0.
- Burst overflow: `tx_ready`=0, six strobes on consecutive cycles with nonces 1..6 →
  - nonce 1 goes into the frame register;
  - nonces 2–5 are stored, `fifo_count`=4;
  - nonce 6 is dropped, `overflow`=1;
  - after release, frames arrive in order 1..5, each separated by one idle cycle; `overflow` stays 1.
- Push/pop collision: FIFO full, and a strobe lands on the IDLE pop cycle →
  - share accepted, `fifo_count` stays DEPTH, `overflow` stays 0.
- Reset mid-frame: `RST` pulsed while byte 5 is presented, with 2 entries queued →
  - next cycle `tx_valid`=0, `fifo_count`=0, `overflow`=0;
  - a new strobe afterwards yields a complete, correct frame.
- Wrap-around: 3×DEPTH shares delivered one at a time →
  - all frames correct and in order across pointer wrap;
  - checksum verified per frame.
